screen_sequencer: RTL and testbench
===================================

Name: screen_sequencer

Overview:
- Frame-synchronous controller that selects which full-screen image (title, Easy/Medium/Hard difficulty, game, game-over) drives the VGA pixel outputs.
- Each image comes from its own ROM/palette renderer.
- Screen changes are requested over a req/ack handshake and sequenced as fade-out, frame-aligned swap, fade-in, so the display never tears.
- Sits between the per-screen renderers and the VGA DAC pins, in the vga_clk domain.

Parameters:
- NUM_SCREENS, 6, number of selectable screens; width of screen index = $clog2(NUM_SCREENS).
- RESET_SCREEN, 0, screen index shown after reset.
- H_TOTAL, 800, DrawX period including blanking.
- V_TOTAL, 525, DrawY period including blanking.
- FRAMES_PER_STEP, 2, frames per one fade-level step; legal range 1..255.

Ports:
- vga_clk  in  1  pixel clock; all logic posedge.
- Reset  in  1  asynchronous, active-high reset.
- DrawX  in  10  current pixel column from the VGA controller.
- DrawY  in  10  current pixel row from the VGA controller.
- blank  in  1  1 = active video, 0 = blanking.
- pix_rgb_in  in  NUM_SCREENS*12  packed renderer colours; screen i at [12*i+11:12*i] = {r[3:0],g[3:0],b[3:0]}.
- screen_req  in  1  request a screen change; held until acked.
- screen_sel  in  $clog2(NUM_SCREENS)  requested screen; stable while screen_req is high.
- req_ack  out  1  one-cycle accept pulse.
- busy  out  1  high in any state other than IDLE.
- cur_screen  out  $clog2(NUM_SCREENS)  screen currently routed to the outputs.
- red, green, blue  out  4 each  registered pixel colour.

Behaviour:
- frame_tick = (DrawX == H_TOTAL-1) && (DrawY == V_TOTAL-1).
  - Asserted for exactly one cycle per frame.
- step counter (8 bit) counts frame_ticks.
  - step_tick fires on the frame_tick that brings the count to FRAMES_PER_STEP; the counter then clears.
  - The counter is cleared on every state entry.
- level: 5-bit brightness, range 0..16.
  - Dimmed channel = (c * level) >> 4, with a 9-bit intermediate.
  - level 16 gives the colour unchanged; level 0 gives black.
- Output register, 1 cycle latency from pix_rgb_in/blank to red/green/blue:
  - If blank = 0, outputs are 0.
  - Otherwise outputs are the dimmed channels of slice cur_screen.
- FSM states:
  - IDLE: level = 16.
    - On screen_req, assert req_ack for 1 cycle.
    - If screen_sel == cur_screen, stay in IDLE.
    - If screen_sel >= NUM_SCREENS, the request is acked and dropped; stay in IDLE.
    - Otherwise latch pending <= screen_sel and go to FADE_OUT.
  - FADE_OUT: on each step_tick, level <= level-1. When the decrement yields 0, go to SWAP.
  - SWAP: one cycle. cur_screen <= pending, then go to FADE_IN.
    - The swap always lands inside vertical blanking, because the last decrement happens on a frame_tick.
  - FADE_IN: on each step_tick, level <= level+1. When the increment yields 16, go to IDLE.
- Handshake:
  - req_ack is issued only in IDLE.
  - A request raised while busy waits; it is acked in the first IDLE cycle.
  - req_ack never asserts in two consecutive cycles; after an ack, screen_req is sampled again no earlier than the next cycle.
  - Requester drops screen_req the cycle after req_ack.
- Full switch duration: 32*FRAMES_PER_STEP frames, plus SWAP.
- Reset (asynchronous, any time, including mid-fade):
  - state = FADE_IN, level = 0, cur_screen = RESET_SCREEN, pending = RESET_SCREEN.
  - step counter = 0, req_ack = 0, red/green/blue = 0, busy = 1.
  - The boot screen therefore fades in over 16 steps.
- Simultaneous events:
  - A step_tick in SWAP is ignored.
  - frame_tick and screen_req in the same IDLE cycle: ack is taken; the step counter is cleared on FADE_OUT entry.
- level never leaves 0..16; no wrap-around.

Decomposition:
- screen_pkg holds:
  - screen_e enum: TITLE, EASY, MEDIUM, HARD, GAME, GAME_OVER.
  - NUM_SCREENS localparam.
  - seq_state_e enum: IDLE, FADE_OUT, SWAP, FADE_IN.
  - LEVEL_MAX = 16.
  - H_TOTAL/V_TOTAL defaults.
- One combinational sub-module, rgb_dimmer: 12-bit colour plus 5-bit level in, 12-bit colour out, three multiply-shift lanes.

Test Plan (FRAMES_PER_STEP = 1; bench drives DrawX/DrawY and may shorten frames):
- Reset release, screen 0 slice = 12'hFFF, blank = 1:
  - level steps 0 -> 16 over 16 frame_ticks.
  - red after 8 ticks = 4'h7 ((15*8)>>4).
  - busy falls on the 16th tick.
  - Final output = 12'hFFF.
- IDLE, screen_req with screen_sel = 3 (HARD):
  - req_ack pulses 1 cycle after the request.
  - Output dims to 0 after 16 ticks.
  - cur_screen becomes 3 one cycle later.
  - Output reaches the slice-3 value after 16 more ticks; busy is low after 32 ticks total.
- screen_req with screen_sel == cur_screen, and separately screen_sel = 7:
  - req_ack pulses in each case.
  - busy stays 0, cur_screen is unchanged, output is undimmed.
- screen_req raised mid-FADE_OUT:
  - No ack until IDLE is re-entered after the first switch completes.
  - Then exactly one ack, and the second switch proceeds.
- Reset asserted at level 5 of FADE_OUT:
  - Outputs go to 0 immediately (async).
  - cur_screen = RESET_SCREEN.
  - Normal fade-in resumes after release.
- blank = 0 during IDLE:
  - red/green/blue = 0 one cycle later.
  - Restored one cycle after blank returns to 1.

Source files
------------

// File: rtl/screen_sequencer_pkg.sv
// Shared types and constants for the screen sequencer.
// Latency: none (declarations only).
// Backpressure: none.
package screen_sequencer_pkg;

    typedef enum logic [2:0] {
        TITLE     = 3'd0,
        EASY      = 3'd1,
        MEDIUM    = 3'd2,
        HARD      = 3'd3,
        GAME      = 3'd4,
        GAME_OVER = 3'd5
    } screen_e;

    localparam int NUM_SCREENS = 6;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_OUT = 2'd1,
        SWAP     = 2'd2,
        FADE_IN  = 2'd3
    } seq_state_e;

    // Brightness runs 0..16, so it needs 5 bits.
    localparam int                 LEVEL_W   = 5;
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = 5'd16;

    localparam int H_TOTAL_DEF = 800;
    localparam int V_TOTAL_DEF = 525;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

endpackage

// File: rtl/screen_sequencer_if.sv
// Bundle of raster, renderer-colour, request handshake and pixel-out signals.
// Latency: none (wiring only).
// Backpressure: screen_req is held by the requester until req_ack pulses.
interface screen_sequencer_if #(
    parameter int NUM_SCREENS = screen_sequencer_pkg::NUM_SCREENS,
    parameter int SEL_W       = $clog2(NUM_SCREENS)
);
    logic [9:0]               DrawX;
    logic [9:0]               DrawY;
    logic                     blank;
    logic [NUM_SCREENS*12-1:0] pix_rgb_in;
    logic                     screen_req;
    logic [SEL_W-1:0]         screen_sel;
    logic                     req_ack;
    logic                     busy;
    logic [SEL_W-1:0]         cur_screen;
    logic [3:0]               red;
    logic [3:0]               green;
    logic [3:0]               blue;

    // Requester / VGA-controller side.
    modport master (
        output DrawX, DrawY, blank, pix_rgb_in, screen_req, screen_sel,
        input  req_ack, busy, cur_screen, red, green, blue
    );

    // Sequencer side.
    modport slave (
        input  DrawX, DrawY, blank, pix_rgb_in, screen_req, screen_sel,
        output req_ack, busy, cur_screen, red, green, blue
    );
endinterface

// File: rtl/screen_sequencer_rgb_dimmer.sv
// Scales a 12-bit colour by a 0..16 brightness level, per channel (c*level)>>4.
// Latency: combinational.
// Backpressure: none.
module rgb_dimmer
    import screen_sequencer_pkg::*;
(
    input  rgb_t               rgb_i,
    input  logic [LEVEL_W-1:0] level_i,
    output rgb_t               rgb_o
);

    // 4-bit channel times 5-bit level fits a 9-bit product; level 16 is identity.
    function automatic logic [3:0] dim_lane(input logic [3:0] c, input logic [LEVEL_W-1:0] l);
        logic [8:0] prod;
        prod = {5'b0, c} * {4'b0, l};
        return 4'(prod >> 4);
    endfunction

    // Three independent multiply-shift lanes.
    always_comb begin
        rgb_o.r = dim_lane(rgb_i.r, level_i);
        rgb_o.g = dim_lane(rgb_i.g, level_i);
        rgb_o.b = dim_lane(rgb_i.b, level_i);
    end

endmodule

// File: rtl/screen_sequencer.sv
// Routes one renderer to the VGA pins; screen changes fade out, swap at frame end, fade in.
// Latency: 1 cycle from pix_rgb_in/blank to red/green/blue; req_ack 1 cycle after sampled req.
// Backpressure: requests arriving while busy wait un-acked until the sequencer is idle.
module screen_sequencer #(
    parameter int NUM_SCREENS     = screen_sequencer_pkg::NUM_SCREENS,
    parameter int RESET_SCREEN    = 0,
    parameter int H_TOTAL         = screen_sequencer_pkg::H_TOTAL_DEF,
    parameter int V_TOTAL         = screen_sequencer_pkg::V_TOTAL_DEF,
    parameter int FRAMES_PER_STEP = 2
) (
    input  logic                vga_clk,
    input  logic                Reset,
    screen_sequencer_if.slave   bus
);
    import screen_sequencer_pkg::*;

    localparam int               SEL_W     = $clog2(NUM_SCREENS);
    localparam logic [9:0]       X_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]       Y_LAST    = 10'(V_TOTAL - 1);
    localparam logic [7:0]       STEP_LAST = 8'(FRAMES_PER_STEP - 1);
    localparam logic [SEL_W-1:0] RESET_SEL = SEL_W'(RESET_SCREEN);

    seq_state_e         state_q;
    logic [LEVEL_W-1:0] level_q;
    logic [7:0]         step_cnt_q;
    logic [SEL_W-1:0]   cur_screen_q;
    logic [SEL_W-1:0]   pending_q;
    logic               req_ack_q;
    logic               busy_q;
    rgb_t               rgb_q;

    logic frame_tick;
    logic step_tick;
    logic sel_valid;
    rgb_t src_rgb;
    rgb_t dim_rgb;

    assign frame_tick = (bus.DrawX == X_LAST) && (bus.DrawY == Y_LAST);
    assign step_tick  = frame_tick && (step_cnt_q == STEP_LAST);
    assign sel_valid  = int'(bus.screen_sel) < NUM_SCREENS;

    // Pick the renderer slice for the screen currently on display.
    always_comb begin
        src_rgb = '0;
        for (int i = 0; i < NUM_SCREENS; i++) begin
            if (cur_screen_q == SEL_W'(i)) begin
                src_rgb = bus.pix_rgb_in[12*i +: 12];
            end
        end
    end

    rgb_dimmer u_dimmer (
        .rgb_i   (src_rgb),
        .level_i (level_q),
        .rgb_o   (dim_rgb)
    );

    // Pixel output register: black during blanking, dimmed colour otherwise.
    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= bus.blank ? dim_rgb : '0;
        end
    end

    // Sequencer FSM with step counter, brightness, screen select and handshake outputs.
    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= FADE_IN;
            level_q      <= '0;
            cur_screen_q <= RESET_SEL;
            pending_q    <= RESET_SEL;
            step_cnt_q   <= '0;
            req_ack_q    <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            req_ack_q <= 1'b0;
            if (step_tick) begin
                step_cnt_q <= '0;
            end else if (frame_tick) begin
                step_cnt_q <= step_cnt_q + 8'd1;
            end

            case (state_q)
                IDLE: begin
                    level_q <= LEVEL_MAX;
                    // The req_ack_q guard keeps a held request from being acked twice.
                    if (bus.screen_req && !req_ack_q) begin
                        req_ack_q <= 1'b1;
                        if (sel_valid && (bus.screen_sel != cur_screen_q)) begin
                            pending_q  <= bus.screen_sel;
                            state_q    <= FADE_OUT;
                            busy_q     <= 1'b1;
                            step_cnt_q <= '0;
                        end
                    end
                end
                FADE_OUT: begin
                    if (step_tick && (level_q != '0)) begin
                        level_q <= level_q - 5'd1;
                        // Last decrement lands on a frame_tick, so SWAP is in vblank.
                        if (level_q == 5'd1) begin
                            state_q    <= SWAP;
                            step_cnt_q <= '0;
                        end
                    end
                end
                SWAP: begin
                    cur_screen_q <= pending_q;
                    state_q      <= FADE_IN;
                    step_cnt_q   <= '0;
                end
                FADE_IN: begin
                    if (step_tick && (level_q != LEVEL_MAX)) begin
                        level_q <= level_q + 5'd1;
                        if (level_q == LEVEL_MAX - 5'd1) begin
                            state_q    <= IDLE;
                            busy_q     <= 1'b0;
                            step_cnt_q <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ack    = req_ack_q;
    assign bus.busy       = busy_q;
    assign bus.cur_screen = cur_screen_q;
    assign bus.red        = rgb_q.r;
    assign bus.green      = rgb_q.g;
    assign bus.blue       = rgb_q.b;

endmodule

// File: tb/tb_screen_sequencer.sv
// Bench for screen_sequencer with a shortened 8x4 raster and one frame per fade step.
// Latency: expectations are sampled 1 ns after the edge that should produce them.
// Backpressure: the bench requester holds screen_req until it sees req_ack.
module tb_screen_sequencer;

    localparam int H = 8;
    localparam int V = 4;

    localparam logic [11:0] S0 = 12'hFFF;
    localparam logic [11:0] S1 = 12'h123;
    localparam logic [11:0] S2 = 12'h456;
    localparam logic [11:0] S3 = 12'hA5C;
    localparam logic [11:0] S4 = 12'h789;
    localparam logic [11:0] S5 = 12'h0F0;

    logic vga_clk = 1'b0;
    logic Reset;
    always #5 vga_clk = ~vga_clk;

    screen_sequencer_if #(.NUM_SCREENS(6)) bus();

    screen_sequencer #(
        .NUM_SCREENS     (6),
        .RESET_SCREEN    (0),
        .H_TOTAL         (H),
        .V_TOTAL         (V),
        .FRAMES_PER_STEP (1)
    ) dut (
        .vga_clk (vga_clk),
        .Reset   (Reset),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;

    // Scoreboard entries: {rgb[11:0], busy, cur_screen[2:0]}.
    logic [15:0] sb[$];

    logic ft;
    assign ft = (bus.DrawX == 10'(H - 1)) && (bus.DrawY == 10'(V - 1));

    function automatic logic [11:0] dim(input logic [11:0] c, input int l);
        dim = {4'((int'(c[11:8]) * l) / 16), 4'((int'(c[7:4]) * l) / 16), 4'((int'(c[3:0]) * l) / 16)};
    endfunction

    function automatic logic [15:0] mk(input logic [11:0] rgb, input logic busy, input logic [2:0] cur);
        mk = {rgb, busy, cur};
    endfunction

    function automatic logic [15:0] obs();
        obs = {bus.red, bus.green, bus.blue, bus.busy, bus.cur_screen};
    endfunction

    // Free-running raster, updated on the falling edge.
    initial begin
        bus.DrawX = '0;
        bus.DrawY = '0;
        forever begin
            @(negedge vga_clk);
            if (bus.DrawX == 10'(H - 1)) begin
                bus.DrawX = '0;
                bus.DrawY = (bus.DrawY == 10'(V - 1)) ? 10'd0 : bus.DrawY + 10'd1;
            end else begin
                bus.DrawX = bus.DrawX + 10'd1;
            end
        end
    end

    // Returns right after the rising edge at which the DUT sees frame_tick.
    task automatic wait_tick();
        int n = 0;
        do begin
            @(posedge vga_clk);
            n++;
        end while (!ft && n < 100);
        checks++;
        if (!ft) begin
            errors++;
            $display("FAIL tick_timeout: no frame_tick after %0d cycles, required within 100", n);
        end
    endtask

    task automatic test_reset();
        Reset          = 1'b1;
        bus.blank      = 1'b1;
        bus.screen_req = 1'b0;
        bus.screen_sel = '0;
        bus.pix_rgb_in = {S5, S4, S3, S2, S1, S0};
        repeat (3) @(posedge vga_clk);
        #1;
        checks++;
        if (obs() !== mk(12'h000, 1'b1, 3'd0)) begin
            errors++;
            $display("FAIL reset_state: got %h required %h", obs(), mk(12'h000, 1'b1, 3'd0));
        end
        checks++;
        if (bus.req_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_ack: got %b required 0", bus.req_ack);
        end
    endtask

    task automatic test_boot(input string tag);
        logic [15:0] e;
        @(negedge vga_clk);
        Reset = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            wait_tick();
            sb.push_back(mk(dim(S0, k), k < 16, 3'd0));
            @(posedge vga_clk);
            #1;
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL %s_level%0d: got %h required %h", tag, k, obs(), e);
            end
            if (k == 8) begin
                checks++;
                if (bus.red !== 4'h7) begin
                    errors++;
                    $display("FAIL %s_red_half: got %h required 7", tag, bus.red);
                end
            end
        end
    endtask

    task automatic do_fade(input logic [11:0] from_rgb, input logic [2:0] from_cur,
                           input logic [2:0] to_sel, input logic [11:0] to_rgb, input string tag);
        logic [15:0] e;
        for (int k = 1; k <= 16; k++) begin
            wait_tick();
            sb.push_back(mk(dim(from_rgb, 16 - k), 1'b1, (k == 16) ? to_sel : from_cur));
            @(posedge vga_clk);
            #1;
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL %s_out%0d: got %h required %h", tag, k, obs(), e);
            end
        end
        for (int k = 1; k <= 16; k++) begin
            wait_tick();
            sb.push_back(mk(dim(to_rgb, k), k < 16, to_sel));
            @(posedge vga_clk);
            #1;
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL %s_in%0d: got %h required %h", tag, k, obs(), e);
            end
        end
    endtask

    task automatic request_and_ack(input logic [2:0] sel, input string tag);
        @(negedge vga_clk);
        bus.screen_req = 1'b1;
        bus.screen_sel = sel;
        @(posedge vga_clk);
        #1;
        checks++;
        if (bus.req_ack !== 1'b1) begin
            errors++;
            $display("FAIL %s_ack: got %b required 1", tag, bus.req_ack);
        end
        @(negedge vga_clk);
        bus.screen_req = 1'b0;
        @(posedge vga_clk);
        #1;
        checks++;
        if (bus.req_ack !== 1'b0) begin
            errors++;
            $display("FAIL %s_ack_pulse: got %b required 0", tag, bus.req_ack);
        end
    endtask

    task automatic test_switch();
        wait_tick();
        request_and_ack(3'd3, "switch");
        do_fade(S0, 3'd0, 3'd3, S3, "switch");
    endtask

    task automatic test_noop(input logic [2:0] sel, input string tag);
        logic [15:0] e;
        request_and_ack(sel, tag);
        sb.push_back(mk(S3, 1'b0, 3'd3));
        repeat (5) @(posedge vga_clk);
        #1;
        e = sb.pop_front();
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL %s_idle: got %h required %h", tag, obs(), e);
        end
    endtask

    task automatic test_pending();
        int acks = 0;
        int n = 0;
        logic [15:0] e;
        wait_tick();
        request_and_ack(3'd1, "pend_first");
        repeat (4) wait_tick();
        @(negedge vga_clk);
        bus.screen_req = 1'b1;
        bus.screen_sel = 3'd5;
        sb.push_back(mk(dim(S1, 15), 1'b0, 3'd1));
        do begin
            @(posedge vga_clk);
            #1;
            n++;
            if (bus.req_ack) acks++;
        end while (bus.busy && n < 2000);
        checks++;
        if (acks !== 0) begin
            errors++;
            $display("FAIL pend_early_ack: got %0d acks while busy, required 0", acks);
        end
        e = sb.pop_front();
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL pend_first_done: got %h required %h", obs(), e);
        end
        @(posedge vga_clk);
        #1;
        checks++;
        if ({bus.req_ack, bus.busy} !== 2'b11) begin
            errors++;
            $display("FAIL pend_ack_busy: got %b required 11", {bus.req_ack, bus.busy});
        end
        @(negedge vga_clk);
        bus.screen_req = 1'b0;
        @(posedge vga_clk);
        #1;
        checks++;
        if (bus.req_ack !== 1'b0) begin
            errors++;
            $display("FAIL pend_single_ack: got %b required 0", bus.req_ack);
        end
        do_fade(S1, 3'd1, 3'd5, S5, "pend_second");
    endtask

    task automatic test_reset_mid();
        logic [15:0] e;
        wait_tick();
        request_and_ack(3'd2, "rstmid");
        repeat (10) wait_tick();
        wait_tick();
        sb.push_back(mk(dim(S5, 5), 1'b1, 3'd5));
        @(posedge vga_clk);
        #1;
        e = sb.pop_front();
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL rstmid_level5: got %h required %h", obs(), e);
        end
        #3;
        Reset = 1'b1;
        #1;
        checks++;
        if (obs() !== mk(12'h000, 1'b1, 3'd0)) begin
            errors++;
            $display("FAIL rstmid_async: got %h required %h", obs(), mk(12'h000, 1'b1, 3'd0));
        end
        repeat (2) @(posedge vga_clk);
        test_boot("reboot");
    endtask

    task automatic test_blank();
        @(negedge vga_clk);
        bus.blank = 1'b0;
        @(posedge vga_clk);
        #1;
        checks++;
        if (obs() !== mk(12'h000, 1'b0, 3'd0)) begin
            errors++;
            $display("FAIL blank_off: got %h required %h", obs(), mk(12'h000, 1'b0, 3'd0));
        end
        @(negedge vga_clk);
        bus.blank = 1'b1;
        @(posedge vga_clk);
        #1;
        checks++;
        if (obs() !== mk(S0, 1'b0, 3'd0)) begin
            errors++;
            $display("FAIL blank_on: got %h required %h", obs(), mk(S0, 1'b0, 3'd0));
        end
    endtask

    initial begin
        test_reset();
        test_boot("boot");
        test_switch();
        test_noop(3'd3, "same");
        test_noop(3'd7, "invalid");
        test_pending();
        test_reset_mid();
        test_blank();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
